// File: rtl/ro10_axil_pkg.sv
// Shared constants, types and helpers for the RO_10 AXI4-Lite register bank.
package ro10_axil_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned IDX_W    = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [IDX_W-1:0] REG_CTRL = 2'd0;
  localparam logic [IDX_W-1:0] REG_SEL  = 2'd1;
  localparam logic [IDX_W-1:0] REG_WIN  = 2'd2;
  localparam logic [IDX_W-1:0] REG_AUX  = 2'd3;

  typedef logic [DATA_W-1:0] reg_arr_t [NUM_REGS];

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Byte-lane merge: lanes with a clear strobe keep the old byte.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ro10_axil_slave.sv
// AXI4-Lite responder for the RO_10 control/status bank: four 32-bit RW
// registers with a one-cycle write-commit pulse per register.
module ro10_axil_slave
  import ro10_axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_areset,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                     s00_axi_awprot,
  input  logic                           s00_axi_awvalid,
  output logic                           s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                           s00_axi_wvalid,
  output logic                           s00_axi_wready,
  output logic [1:0]                     s00_axi_bresp,
  output logic                           s00_axi_bvalid,
  input  logic                           s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                     s00_axi_arprot,
  input  logic                           s00_axi_arvalid,
  output logic                           s00_axi_arready,
  output logic [DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                     s00_axi_rresp,
  output logic                           s00_axi_rvalid,
  input  logic                           s00_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            reg_wr_pulse_o
);

  wr_state_e               wr_state_q, wr_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [NUM_REGS-1:0]     pulse_q, pulse_d;
  reg_arr_t                regs_q, regs_d;

  rd_state_e               rd_state_q, rd_state_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;

  // Write path: independent AW/W capture slots, commit once both are held.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    pulse_d    = '0;
    regs_d     = regs_q;

    case (wr_state_q)
      W_IDLE: begin
        if (s00_axi_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s00_axi_awaddr[3:2];
        end
        if (s00_axi_wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = s00_axi_wdata;
          wstrb_d  = s00_axi_wstrb;
        end
        // Readies are low while both slots are held, so no capture races this.
        if (aw_held_q && w_held_q) begin
          regs_d[aw_idx_q]  = merge_bytes(regs_q[aw_idx_q], wdata_q, wstrb_q);
          pulse_d[aw_idx_q] = 1'b1;
          aw_held_d         = 1'b0;
          w_held_d          = 1'b0;
          bvalid_d          = 1'b1;
          wr_state_d        = W_RESP;
        end
      end
      W_RESP: begin
        if (s00_axi_bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: begin
        wr_state_d = W_IDLE;
        bvalid_d   = 1'b0;
      end
    endcase

    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end

  // Read path: single outstanding read, data sampled from the pre-commit bank.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;

    case (rd_state_q)
      R_IDLE: begin
        if (s00_axi_arvalid && arready_q) begin
          rdata_d    = regs_q[s00_axi_araddr[3:2]];
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s00_axi_rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
        rvalid_d   = 1'b0;
      end
    endcase

    arready_d = !rvalid_d;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      pulse_q    <= '0;
      regs_q     <= '{default: '0};
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      pulse_q    <= pulse_d;
      regs_q     <= regs_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = RESP_OKAY;
  assign reg_wr_pulse_o  = pulse_q;
  assign regs_o          = {regs_q[REG_AUX], regs_q[REG_WIN], regs_q[REG_SEL], regs_q[REG_CTRL]};

  // Protection bits and sub-word/upper address bits are intentionally ignored.
  logic unused_ok;
  assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

endmodule

// File: tb/tb_ro10_axil_slave.sv
// Self-checking bench for ro10_axil_slave: directed scenarios plus randomized
// traffic against a register-array reference model.
module tb_ro10_axil_slave;

  logic         clk;
  logic         areset;
  logic [3:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] regs;
  logic [3:0]   pulse;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [4];

  ro10_axil_slave dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (areset),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .regs_o          (regs),
    .reg_wr_pulse_o  (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  // w_lead > 0: W presented that many cycles before AW; < 0: AW leads.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_wait);
    int aw_start, w_start, cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [31:0] mask;
    int idx;
    idx      = int'(addr[3:2]);
    mask     = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    awaddr = addr; wdata = data; wstrb = strb; awprot = 3'($urandom);
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done)) begin
      if (cyc > 40) begin
        check("wr_handshake_timeout", 0, 1);
        break;
      end
      awvalid = !aw_done && (cyc >= aw_start);
      wvalid  = !w_done && (cyc >= w_start);
      aw_hs   = awvalid && awready;
      w_hs    = wvalid && wready;
      @(negedge clk);
      if (aw_hs) begin aw_done = 1; check("awready_drop", awready, 0); end
      if (w_hs)  begin w_done = 1;  check("wready_drop", wready, 0);  end
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    check("bvalid_not_early", bvalid, 0);
    @(negedge clk);
    model[idx] = (model[idx] & ~mask) | (data & mask);
    check("bvalid_set", bvalid, 1);
    check("bresp", bresp, 2'b00);
    check("wr_pulse", pulse, 4'b0001 << idx);
    check("regs_after_write", regs, model_flat());
    for (int i = 0; i < b_wait; i++) begin
      awvalid = 1; wvalid = 1; awaddr = 4'($urandom);
      @(negedge clk);
      check("bvalid_hold", bvalid, 1);
      check("awready_blocked", awready, 0);
      check("wready_blocked", wready, 0);
    end
    awvalid = 0; wvalid = 0; bready = 1;
    @(negedge clk);
    bready = 0;
    check("bvalid_clear", bvalid, 0);
    check("pulse_one_cycle", pulse, 0);
    check("awready_back", awready, 1);
    check("wready_back", wready, 1);
    check("regs_stable", regs, model_flat());
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_wait);
    logic [31:0] exp;
    int cyc;
    bit hs;
    exp = model[addr[3:2]];
    araddr = addr; arprot = 3'($urandom); arvalid = 1;
    cyc = 0; hs = 0;
    while (!hs) begin
      if (cyc > 40) begin
        check("ar_handshake_timeout", 0, 1);
        break;
      end
      hs = arready;
      @(negedge clk);
      cyc++;
    end
    arvalid = 0;
    check("rvalid_set", rvalid, 1);
    check("rdata", rdata, exp);
    check("rresp", rresp, 2'b00);
    check("arready_drop", arready, 0);
    for (int i = 0; i < r_wait; i++) begin
      @(negedge clk);
      check("rvalid_hold", rvalid, 1);
      check("rdata_stable", rdata, exp);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    check("rvalid_clear", rvalid, 0);
    check("arready_back", arready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_regs", regs, 0);
    check("rst_pulse", pulse, 0);
    areset = 0;
    @(negedge clk);
    check("rel_awready", awready, 1);
    check("rel_wready", wready, 1);
    check("rel_arready", arready, 1);

    // Sequential write then read-back
    for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(4 * i), 0);
    check("seq_regs", regs, {32'd4, 32'd3, 32'd2, 32'd1});

    // W leads AW by 3 cycles
    axi_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 0);
    axi_read(4'h8, 0);

    // Byte strobes
    axi_write(4'h4, 32'h11223344, 4'hF, 0, 0);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0101, -2, 0);
    check("strb_model", model[1], 32'h11BB33DD);
    axi_read(4'h4, 0);

    // Zero strobe still commits and pulses
    axi_write(4'h0, 32'hFFFFFFFF, 4'h0, 0, 0);

    // Backpressure on B and R
    axi_write(4'hC, 32'h0BADF00D, 4'hF, 0, 10);
    axi_read(4'hC, 10);

    // Read captured on the same edge as a commit to the same register
    axi_write(4'hC, 32'h5, 4'hF, 0, 0);
    awaddr = 4'hC; wdata = 32'h9; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; araddr = 4'hC; arvalid = 1;
    @(negedge clk);
    arvalid = 0;
    model[3] = 32'h9;
    check("coll_bvalid", bvalid, 1);
    check("coll_rvalid", rvalid, 1);
    check("coll_rdata_old", rdata, 32'h5);
    check("coll_regs", regs, model_flat());
    bready = 1; rready = 1;
    @(negedge clk);
    bready = 0; rready = 0;
    axi_read(4'hC, 0);

    // Aliased addresses in random traffic
    for (int n = 0; n < 60; n++) begin
      logic [3:0] a;
      logic [3:0] s;
      a = 4'($urandom);
      s = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
      else
        axi_read(a, int'($urandom_range(0, 3)));
    end

    // Reset while both B and R are pending
    awaddr = 4'h4; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 4'h0; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    check("pre_rst_bvalid", bvalid, 1);
    check("pre_rst_rvalid", rvalid, 1);
    areset = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) model[i] = '0;
    check("mid_rst_bvalid", bvalid, 0);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_awready", awready, 0);
    check("mid_rst_wready", wready, 0);
    check("mid_rst_arready", arready, 0);
    check("mid_rst_regs", regs, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_pulse", pulse, 0);
    areset = 0;
    @(negedge clk);
    check("post_rst_awready", awready, 1);
    check("post_rst_wready", wready, 1);
    check("post_rst_arready", arready, 1);
    axi_write(4'h8, 32'hCAFEF00D, 4'hF, -1, 1);
    axi_read(4'h8, 1);
    axi_read(4'h4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ro10_axil_slave.md
Name: ro10_axil_slave

Overview:
AXI4-Lite responder (slave) for the RO_10 control/status register bank. It terminates the AXI4-Lite master traffic that bench VIPs and the PS generate. It holds 4 x 32-bit read/write registers, drives them to the ring-oscillator core, and pulses a per-register write strobe. Sits between the AXI interconnect and the RO_10 core logic.

Parameters:
DATA_WIDTH, 32, AXI data width (only 32 supported)
ADDR_WIDTH, 4, AXI address width; only bits [3:2] decoded, all other bits ignored (aliasing)
NUM_REGS, 4, register count (fixed at 4 by the [3:2] decode)

Ports:
s00_axi_aclk  in  1  single clock for all logic
s00_axi_areset  in  1  synchronous, active-high reset
s00_axi_awaddr  in  ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address ready
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data ready
s00_axi_bresp  out  2  always OKAY (2'b00)
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address ready
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  always OKAY
s00_axi_rvalid  out  1  read data valid
s00_axi_rready  in  1  read data ready
regs_o  out  4*32  register contents; reg k at bits [32k+31:32k]
reg_wr_pulse_o  out  4  one-cycle pulse per register on commit

Behaviour:
- Reset (sync, active-high, sampled on rising edge): all registers 0; regs_o = 0; all ready/valid outputs 0; rdata = 0; reg_wr_pulse_o = 0; aw/w holding flags cleared. Any in-flight transaction is dropped with no B/R issued.
- Readies are registered outputs. They go high on the first edge after reset deasserts.
- Write channel:
  - Independent AW and W slots. awready = !aw_held && !bvalid. wready = !w_held && !bvalid.
  - A handshake (valid && ready at an edge) captures addr or data+strb, sets the held flag, and drops the matching ready the next cycle.
  - AW and W may arrive in either order or in the same cycle.
  - Commit: the cycle both held flags are set, register [awaddr[3:2]] is updated bytewise per wstrb (strb 0 keeps the old byte). On the same edge bvalid is set, the held flags clear, and reg_wr_pulse_o[idx] pulses for exactly 1 cycle.
  - Latency: AW+W handshake at edge N, commit and bvalid high after edge N+1.
  - bvalid holds until bready. awready/wready reassert the cycle after the B handshake.
  - wstrb = 0: the commit still occurs, the register is unchanged, and the pulse still fires.
- Read channel:
  - arready = !rvalid.
  - AR handshake at edge N: rdata <= reg[araddr[3:2]] and rvalid = 1 after edge N (1-cycle latency).
  - rdata/rvalid are held stable until rready. arready reasserts the cycle after the R handshake.
- Read/write collision: a read captured on the same edge as a commit to the same register returns the old value.
- Back-to-back: maximum throughput is 1 write per 3 cycles and 1 read per 2 cycles with bready/rready tied high. No outstanding-transaction depth beyond 1 per channel.
- bresp/rresp are constant 2'b00. No SLVERR is generated.

Decomposition:
- Package ro10_axil_pkg holds:
  - RESP_OKAY = 2'b00
  - NUM_REGS = 4
  - register index constants: REG_CTRL = 0, REG_SEL = 1, REG_WIN = 2, REG_AUX = 3
  - the regs array typedef (logic [31:0] reg_arr_t [4])
- No sub-module. The write FSM (IDLE/RESP, plus held flags) and the read FSM (IDLE/DATA) live in one file.

Test Plan:
- Sequential write/read: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read all four back -> rdata 0x1, 0x2, 0x3, 0x4; bresp/rresp = 00; regs_o = {4, 3, 2, 1}.
- Ordering: W (0xDEADBEEF) presented 3 cycles before AW (addr 0x8) -> a single commit, reg2 = 0xDEADBEEF, reg_wr_pulse_o = 4'b0100 for 1 cycle, bvalid 1 cycle after the later handshake.
- Byte strobe: reg1 = 0x11223344, then write 0xAABBCCDD with wstrb 4'b0101 -> read 0x11BB33DD.
- Backpressure: hold bready = 0 for 10 cycles -> bvalid stays high, awready/wready stay low, and a second AW is not accepted. With rready = 0, rdata is held stable.
- Collision: reg3 = 0x5; read 0xC on the same edge as the commit of 0x9 to 0xC -> R returns 0x5; the next read returns 0x9.
- Reset mid-operation: assert reset while bvalid = 1 and rvalid = 1 -> the next cycle all valids/readies are 0 and regs_o = 0; after release, readies are 1 and a fresh write/read works.
